// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scanner.
// The content struct carries the brightness field only when SEG7_DIM_EN is defined.
package seg7_pkg;

    localparam int DIGITS = 8;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high gfedcba patterns for 0..F.
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } slot_state_t;

    typedef struct packed {
`ifdef SEG7_DIM_EN
        logic [3:0]  bright;
`endif
        logic [7:0]  blank;
        logic [7:0]  dp;
        logic [31:0] hex;
    } content_t;

    function automatic content_t content_rst();
        content_t c;
        c       = '0;
        c.blank = '1;
`ifdef SEG7_DIM_EN
        c.bright = '1;
`endif
        return c;
    endfunction

endpackage

// File: rtl/seg7_hexdec.sv
// Combinational hex nibble to active-high gfedcba glyph decoder.
module seg7_hexdec
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph
);

    assign glyph = GLYPH[nib];

endmodule

// File: rtl/seg7_scan.sv
// 8-digit multiplexed 7-segment scanner with double-buffered content and per-slot dead-time.
// All outputs registered; optional PWM dimming during ON when SEG7_DIM_EN is defined.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [31:0] hex,
    input  logic [7:0]  dp,
    input  logic [7:0]  blank,
    input  logic [3:0]  bright,
    input  logic        update,
    output logic [7:0]  dig,
    output logic [7:0]  seg,
    output logic        frame_start
);

    localparam int PERIOD = CLK_HZ / SCAN_HZ;
    localparam int CW     = $clog2(PERIOD);
    localparam int IW     = $clog2(DIGITS);
    localparam slot_state_t FIRST_STATE = (BLANK_CYCLES == 0) ? ON : BLANK;

    logic [CW-1:0] cnt, nxt_cnt;
    logic [IW-1:0] idx, nxt_idx;
    slot_state_t   state, nxt_state;
    logic          run;
    content_t      pending, active, act_nxt, in_c;
    logic [6:0]    glyph;
    logic [7:0]    dig_d, seg_d;
    logic          lit;

`ifdef SEG7_DIM_EN
    logic [3:0] pwm, nxt_pwm;
`else
    logic unused_bright;
    assign unused_bright = ^bright;
`endif

    always_comb begin
        in_c       = '0;
        in_c.hex   = hex;
        in_c.dp    = dp;
        in_c.blank = blank;
`ifdef SEG7_DIM_EN
        in_c.bright = bright;
`endif
    end

    // The counters describe the slot position the outputs currently show; run holds
    // the first post-reset edge at position 0 so frame_start fires right away.
    always_comb begin
        nxt_cnt   = cnt;
        nxt_idx   = idx;
        nxt_state = state;
        if (run) begin
            if (cnt == CW'(PERIOD - 1)) begin
                nxt_cnt   = '0;
                nxt_idx   = idx + IW'(1);
                nxt_state = FIRST_STATE;
            end else begin
                nxt_cnt = cnt + CW'(1);
                if (cnt + CW'(1) == CW'(BLANK_CYCLES))
                    nxt_state = ON;
            end
        end
    end

    // Frame boundary is the whole first cycle of digit 0; an update strobed then wins over pending.
    always_comb begin
        act_nxt = active;
        if (run && cnt == '0 && idx == '0)
            act_nxt = update ? in_c : pending;
    end

    seg7_hexdec u_hexdec (
        .nib   (act_nxt.hex[{nxt_idx, 2'b00} +: 4]),
        .glyph (glyph)
    );

`ifdef SEG7_DIM_EN
    always_comb begin
        nxt_pwm = '0;
        if (nxt_state == ON && state == ON)
            nxt_pwm = pwm + 4'd1;
    end
    assign lit = (nxt_pwm <= act_nxt.bright);
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        dig_d = 8'hFF;
        seg_d = 8'hFF;
        if (nxt_state == ON && !act_nxt.blank[nxt_idx] && lit) begin
            dig_d[nxt_idx]      = 1'b0;
            seg_d[SEG_G:SEG_A]  = ~glyph;
            seg_d[SEG_DP]       = ~act_nxt.dp[nxt_idx];
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            state       <= FIRST_STATE;
            run         <= 1'b0;
            pending     <= content_rst();
            active      <= content_rst();
            dig         <= 8'hFF;
            seg         <= 8'hFF;
            frame_start <= 1'b0;
`ifdef SEG7_DIM_EN
            pwm         <= '0;
`endif
        end else begin
            run         <= 1'b1;
            cnt         <= nxt_cnt;
            idx         <= nxt_idx;
            state       <= nxt_state;
            active      <= act_nxt;
            if (update)
                pending <= in_c;
            dig         <= dig_d;
            seg         <= seg_d;
            frame_start <= (nxt_cnt == '0) && (nxt_idx == '0);
`ifdef SEG7_DIM_EN
            pwm         <= nxt_pwm;
`endif
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: reset, idle frames, double buffering, blanking, mid-frame reset, optional dimming.
module tb_seg7_scan;

`ifdef SEG7_DIM_EN
    localparam int CLK = 3400;
`else
    localparam int CLK = 1000;
`endif
    localparam int SCAN  = 100;
    localparam int P     = CLK / SCAN;
    localparam int B     = 2;
    localparam int FRAME = 8 * P;

    typedef struct packed {
        logic [31:0] h;
        logic [7:0]  d;
        logic [7:0]  b;
    } cont_t;

    localparam cont_t IDLE = '{h: 32'h0,         d: 8'h00, b: 8'hFF};
    localparam cont_t C1   = '{h: 32'h0123_4567, d: 8'h00, b: 8'h00};
    localparam cont_t C2   = '{h: 32'hFFFF_FFF8, d: 8'h01, b: 8'h02};
    localparam cont_t H1   = '{h: 32'h0000_0001, d: 8'h00, b: 8'h00};
    localparam cont_t H2   = '{h: 32'h0000_0002, d: 8'h00, b: 8'h00};
    localparam cont_t C3   = '{h: 32'h89AB_CDEF, d: 8'hAA, b: 8'h00};

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [31:0] hex;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [3:0]  bright;
    logic        update;
    logic [7:0]  dig;
    logic [7:0]  seg;
    logic        frame_start;

    int n_checks = 0;
    int n_errors = 0;

    seg7_scan #(
        .CLK_HZ       (CLK),
        .SCAN_HZ      (SCAN),
        .BLANK_CYCLES (B)
    ) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .hex         (hex),
        .dp          (dp),
        .blank       (blank),
        .bright      (bright),
        .update      (update),
        .dig         (dig),
        .seg         (seg),
        .frame_start (frame_start)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Expected pins at offset k from the frame_start cycle.
    function automatic logic [7:0] exp_dig(input cont_t c, input int k);
        int i = k / P;
        if ((k % P) < B || c.b[i]) return 8'hFF;
        return ~(8'h01 << i);
    endfunction

    function automatic logic [7:0] exp_seg(input cont_t c, input int k);
        int i = k / P;
        if ((k % P) < B || c.b[i]) return 8'hFF;
        return {~c.d[i], ~glyph_of(c.h[4*i +: 4])};
    endfunction

    task automatic drive_update(input cont_t c);
        update = 1'b1;
        hex    = c.h;
        dp     = c.d;
        blank  = c.b;
    endtask

    // Starts at the frame_start cycle and ends on the last cycle of that frame.
    task automatic check_frame(input string tag, input cont_t e,
                               input int u1, input cont_t c1, input int u2, input cont_t c2);
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk_sys);
            check($sformatf("%s_fs@%0d", tag, k), frame_start, (k == 0));
            check($sformatf("%s_dig@%0d", tag, k), dig, exp_dig(e, k));
            check($sformatf("%s_seg@%0d", tag, k), seg, exp_seg(e, k));
            update = 1'b0;
            if (k == u1) drive_update(c1);
            if (k == u2) drive_update(c2);
        end
    endtask

    task automatic wait_frame(input int exp_steps);
        int t = 0;
        do begin
            @(negedge clk_sys);
            t++;
        end while (frame_start !== 1'b1 && t < FRAME + 2);
        update = 1'b0;
        check("frame_period", t, exp_steps);
    endtask

`ifdef SEG7_DIM_EN
    task automatic dim_frame(input int cur_bright, input int exp_lit, input logic [3:0] new_bright);
        int lit = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk_sys);
            update = 1'b0;
            if (k >= B && k < P) begin
                check($sformatf("dim_dig@%0d", k), dig,
                      (((k - B) % 16) <= cur_bright) ? 8'hFE : 8'hFF);
                if (dig == 8'hFE) lit++;
            end
            if (k == 5) begin
                bright = new_bright;
                drive_update(C1);
            end
        end
        check("dim_lit_count", lit, exp_lit);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        update = 1'b0;
        hex    = '0;
        dp     = '0;
        blank  = '0;
        bright = 4'd15;
        repeat (3) @(negedge clk_sys);
        check("rst_dig", dig, 8'hFF);
        check("rst_seg", seg, 8'hFF);
        check("rst_fs",  frame_start, 1'b0);

        rst = 1'b0;
        @(negedge clk_sys);
        check_frame("idle0", IDLE, -1, IDLE, -1, IDLE);
        wait_frame(1);
        check_frame("idle1", IDLE, 10, C1, -1, C1);
        wait_frame(1);
        check_frame("cnt", C1, 20, C2, -1, C2);
        wait_frame(1);
        check_frame("dpblank", C2, 5, H1, 30, H2);
        wait_frame(1);
        check_frame("lastwins", H2, -1, H2, -1, H2);
        wait_frame(1);
        check_frame("fsupd", C3, 0, C3, -1, C3);

        wait_frame(1);
        repeat (3 * P + B + 1) @(negedge clk_sys);
        check("d3_dig", dig, 8'hF7);
        check("d3_seg", seg, exp_seg(C3, 3 * P + B + 1));
        rst = 1'b1;
        @(negedge clk_sys);
        check("midrst_dig", dig, 8'hFF);
        check("midrst_seg", seg, 8'hFF);
        check("midrst_fs",  frame_start, 1'b0);
        rst = 1'b0;
        @(negedge clk_sys);
        check_frame("postrst", IDLE, -1, IDLE, -1, IDLE);

`ifdef SEG7_DIM_EN
        bright = 4'd3;
        wait_frame(1);
        check_frame("dimpre", IDLE, 5, C1, -1, C1);
        wait_frame(1);
        dim_frame(3, 8, 4'd15);
        wait_frame(1);
        dim_frame(15, P - B, 4'd15);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
